// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;
   localparam int AW_DEF    = 32;
   localparam int DW_DEF    = 32;
   localparam int DEPTH_DEF = 4;
   typedef logic id_t;
   typedef struct packed {
      logic [AW_DEF-1:0]   addr;
      logic                we;
      logic [DW_DEF-1:0]   wdata;
      logic [DW_DEF/8-1:0] wstrb;
   } req_t;
endpackage

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: DEPTH x 1-bit in-order FIFO of requester IDs for outstanding transactions.
module mem_arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  id_t           din,
   output id_t           head,
   output logic [CW-1:0] count
);
   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wp, rp;
   always_ff @(posedge clock) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= wp + PW'(1);
         end
         if (pop) rp <= rp + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign head = mem[rp];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (r0) and data (r1), routing in-order responses.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise r1 has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic [AW-1:0]   r0_addr,
   input  logic            r0_we,
   input  logic [DW-1:0]   r0_wdata,
   input  logic [DW/8-1:0] r0_wstrb,
   output logic            r0_s_valid,
   input  logic            r0_s_ready,
   output logic [DW-1:0]   r0_s_data,
   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic [AW-1:0]   r1_addr,
   input  logic            r1_we,
   input  logic [DW-1:0]   r1_wdata,
   input  logic [DW/8-1:0] r1_wstrb,
   output logic            r1_s_valid,
   input  logic            r1_s_ready,
   output logic [DW-1:0]   r1_s_data,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic            mem_s_valid,
   output logic            mem_s_ready,
   input  logic [DW-1:0]   mem_s_data,
   output logic            error
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          slot_free, can_grant, grant, has, pop;
   id_t           win, head;
   logic [CW-1:0] count;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   id_t last;
`endif
   always_comb begin
      slot_free = !mem_valid | mem_ready;
      // a same-cycle pop is ignored here, so a full FIFO stalls one extra cycle
      can_grant = slot_free & (count < CW'(DEPTH));
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = r1_valid & (!r0_valid | !last);
`else
      win = r1_valid;
`endif
      r1_ready    = can_grant & win;
      r0_ready    = can_grant & r0_valid & !win;
      grant       = r0_ready | r1_ready;
      has         = count != '0;
      r0_s_valid  = mem_s_valid & has & !head;
      r1_s_valid  = mem_s_valid & has & head;
      mem_s_ready = has ? (head ? r1_s_ready : r0_s_ready) : 1'b1;
      pop         = mem_s_valid & mem_s_ready & has;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         error     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last      <= 1'b1;
`endif
      end else begin
         if (grant) begin
            mem_valid <= 1'b1;
            mem_addr  <= win ? r1_addr : r0_addr;
            mem_we    <= win ? r1_we : r0_we;
            mem_wdata <= win ? r1_wdata : r0_wdata;
            mem_wstrb <= win ? r1_wstrb : r0_wstrb;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last      <= win;
`endif
         end else if (mem_ready) begin
            mem_valid <= 1'b0;
         end
         error <= error | (mem_s_valid & !has);
      end
   end
   assign r0_s_data = mem_s_data;
   assign r1_s_data = mem_s_data;
   mem_arb_id_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (grant),
      .pop  (pop),
      .din  (win),
      .head (head),
      .count(count)
   );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with request/response scoreboards checked by a negedge monitor.
module tb_mem_arbiter;
   logic        clock = 1'b0, reset = 1'b1;
   logic        r0_valid, r0_ready, r0_we, r0_s_valid, r0_s_ready;
   logic        r1_valid, r1_ready, r1_we, r1_s_valid, r1_s_ready;
   logic [31:0] r0_addr, r0_wdata, r0_s_data, r1_addr, r1_wdata, r1_s_data;
   logic [3:0]  r0_wstrb, r1_wstrb, mem_wstrb;
   logic        mem_valid, mem_ready, mem_we, mem_s_valid, mem_s_ready, error;
   logic [31:0] mem_addr, mem_wdata, mem_s_data;

   typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} req_s;
   typedef struct {logic id; logic [31:0] data; logic chk_data;} rsp_s;
   req_s req_q[$];
   rsp_s rsp_q[$];
   int   checks = 0, errors = 0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
      .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb), .r0_s_valid(r0_s_valid),
      .r0_s_ready(r0_s_ready), .r0_s_data(r0_s_data),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
      .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb), .r1_s_valid(r1_s_valid),
      .r1_s_ready(r1_s_ready), .r1_s_data(r1_s_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_s_valid(mem_s_valid),
      .mem_s_ready(mem_s_ready), .mem_s_data(mem_s_data), .error(error)
   );

   task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic rsp_check(logic id, logic [31:0] data);
      rsp_s e;
      if (rsp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_unexpected: got id %0d expected no response", id);
      end else begin
         e = rsp_q.pop_front();
         chk("rsp_id", 96'(id), 96'(e.id));
         if (e.chk_data) chk("rsp_data", 96'(data), 96'(e.data));
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (mem_valid && mem_ready) begin
            if (req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL req_unexpected: got addr %0h expected no request", mem_addr);
            end else begin
               req_s e;
               e = req_q.pop_front();
               chk("mem_req", {27'd0, mem_addr, mem_we, mem_wdata, mem_wstrb},
                   {27'd0, e.addr, e.we, e.wdata, e.wstrb});
            end
         end
         if (r0_s_valid && r0_s_ready) rsp_check(1'b0, r0_s_data);
         if (r1_s_valid && r1_s_ready) rsp_check(1'b1, r1_s_data);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic exp_req(logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s);
      req_s e;
      e.addr = a; e.we = w; e.wdata = d; e.wstrb = s;
      req_q.push_back(e);
   endtask

   task automatic exp_rsp(logic id, logic [31:0] d, logic c);
      rsp_s e;
      e.id = id; e.data = d; e.chk_data = c;
      rsp_q.push_back(e);
   endtask

   task automatic idle();
      r0_valid = 0; r0_addr = 0; r0_we = 0; r0_wdata = 0; r0_wstrb = 0; r0_s_ready = 1;
      r1_valid = 0; r1_addr = 0; r1_we = 0; r1_wdata = 0; r1_wstrb = 0; r1_s_ready = 1;
      mem_ready = 1; mem_s_valid = 0; mem_s_data = 0;
   endtask

   task automatic do_reset();
      chk("leftover", 96'(req_q.size() + rsp_q.size()), 96'd0);
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
      req_q.delete();
      rsp_q.delete();
   endtask

   function automatic logic winner(int i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return i[0];
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      idle();
      do_reset();
      #1;
      chk("rst_mem_valid", 96'(mem_valid), 96'd0);
      chk("rst_error", 96'(error), 96'd0);
      chk("rst_mem_s_ready", 96'(mem_s_ready), 96'd1);
      chk("rst_ready", 96'({r0_ready, r1_ready}), 96'd0);

      // single read
      r0_valid = 1; r0_addr = 32'h200; r0_wstrb = 4'hF;
      #1;
      chk("t1_ready", 96'({r0_ready, r1_ready}), 96'b10);
      exp_req(32'h200, 0, 0, 4'hF);
      exp_rsp(0, 32'h1234_5678, 1);
      tick();
      r0_valid = 0;
      #1;
      chk("t1_mem_out", 96'({mem_valid, mem_addr}), {63'd0, 1'b1, 32'h200});
      tick();
      mem_s_valid = 1; mem_s_data = 32'h1234_5678;
      #1;
      chk("t1_s_valid", 96'({r0_s_valid, r1_s_valid}), 96'b10);
      tick();
      mem_s_valid = 0;

      // contention, then FIFO-full stall, then in-order routing
      do_reset();
      r0_valid = 1; r0_addr = 32'h100; r0_we = 0; r0_wdata = 0; r0_wstrb = 4'hF;
      r1_valid = 1; r1_addr = 32'h300; r1_we = 1; r1_wdata = 32'hDEAD_0001; r1_wstrb = 4'h3;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_grant", 96'({r0_ready, r1_ready}), winner(i) ? 96'b01 : 96'b10);
         if (winner(i)) begin
            exp_req(32'h300, 1, 32'hDEAD_0001, 4'h3);
            exp_rsp(1, 0, 0);
         end else begin
            exp_req(32'h100, 0, 0, 4'hF);
            exp_rsp(0, 32'hA0 + 32'(i), 1);
         end
         tick();
      end
      #1;
      chk("t2_full_stall", 96'({r0_ready, r1_ready}), 96'd0);
      tick();
      r0_valid = 0; r1_valid = 0;
      for (int i = 0; i < 4; i++) begin
         mem_s_valid = 1; mem_s_data = 32'hA0 + 32'(i);
         #1;
         chk("t2_route", 96'({r0_s_valid, r1_s_valid}), winner(i) ? 96'b01 : 96'b10);
         tick();
      end
      mem_s_valid = 0;

      // request backpressure
      do_reset();
      mem_ready = 0;
      r0_valid = 1; r0_addr = 32'h400; r0_we = 1; r0_wdata = 32'h1111_2222; r0_wstrb = 4'h5;
      #1;
      chk("t3_first_ready", 96'(r0_ready), 96'd1);
      exp_req(32'h400, 1, 32'h1111_2222, 4'h5);
      exp_rsp(0, 0, 0);
      tick();
      r0_addr = 32'h404; r0_wdata = 32'h3333_4444;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_ready_low", 96'(r0_ready), 96'd0);
         chk("t3_hold", 96'({mem_valid, mem_addr, mem_wdata}), {31'd0, 1'b1, 32'h400, 32'h1111_2222});
         tick();
      end
      mem_ready = 1;
      #1;
      chk("t3_release", 96'(r0_ready), 96'd1);
      exp_req(32'h404, 1, 32'h3333_4444, 4'h5);
      exp_rsp(0, 0, 0);
      tick();
      r0_valid = 0;
      tick();
      mem_s_valid = 1;
      tick();
      tick();
      mem_s_valid = 0; r0_s_ready = 0;
      #1;
      chk("t3_drained", 96'(mem_s_ready), 96'd1);
      r0_s_ready = 1;

      // response stall on r1 at head
      do_reset();
      r1_valid = 1; r1_addr = 32'h500; r1_we = 0; r1_wstrb = 4'hF;
      #1;
      chk("t4_r1_ready", 96'(r1_ready), 96'd1);
      exp_req(32'h500, 0, 0, 4'hF);
      exp_rsp(1, 32'hBEEF, 1);
      tick();
      r1_valid = 0;
      r0_valid = 1; r0_addr = 32'h600; r0_we = 0; r0_wdata = 0; r0_wstrb = 4'hF;
      #1;
      chk("t4_r0_ready", 96'(r0_ready), 96'd1);
      exp_req(32'h600, 0, 0, 4'hF);
      exp_rsp(0, 32'hCAFE, 1);
      tick();
      r0_valid = 0;
      tick();
      r1_s_ready = 0; mem_s_valid = 1; mem_s_data = 32'hBEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t4_stall", 96'({mem_s_ready, r1_s_valid, r0_s_valid}), 96'b010);
         tick();
      end
      r1_s_ready = 1;
      #1;
      chk("t4_release", 96'(mem_s_ready), 96'd1);
      tick();
      mem_s_data = 32'hCAFE;
      #1;
      chk("t4_second", 96'({r0_s_valid, r1_s_valid}), 96'b10);
      tick();
      mem_s_valid = 0;

      // orphan response sets sticky error; reset clears outstanding state
      do_reset();
      mem_s_valid = 1; mem_s_data = 32'h77;
      #1;
      chk("t5_orphan", 96'({mem_s_ready, r0_s_valid, r1_s_valid, error}), 96'b1000);
      tick();
      mem_s_valid = 0;
      #1;
      chk("t5_error", 96'(error), 96'd1);
      r0_valid = 1; r0_addr = 32'h700; r0_we = 0; r0_wstrb = 4'hF;
      exp_req(32'h700, 0, 0, 4'hF);
      tick();
      r0_valid = 0;
      r1_valid = 1; r1_addr = 32'h704; r1_we = 0; r1_wstrb = 4'hF;
      exp_req(32'h704, 0, 0, 4'hF);
      tick();
      r1_valid = 0; mem_ready = 0;
      #1;
      chk("t5_sticky", 96'({error, mem_valid}), 96'b11);
      reset = 1;
      tick();
      reset = 0; r0_s_ready = 0; r1_s_ready = 0;
      req_q.delete();
      rsp_q.delete();
      #1;
      chk("t5_after_reset", 96'({mem_valid, error, mem_s_ready}), 96'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between two requesters: r0 (instruction fetch) and r1 (data load/store).
- Arbitrates the request channel and registers the winner toward memory.
- Tracks outstanding transactions in order and routes each in-order response beat back to the requester that issued it.
- Sits between the core's fetch/data units and the single memory slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width (DW/8 byte strobes).
- DEPTH, 4, maximum outstanding transactions (power of 2, ≥2).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- r0_valid / r1_valid  input  1  request valid
- r0_ready / r1_ready  output  1  request accepted this cycle
- r0_addr / r1_addr  input  AW  request address
- r0_we / r1_we  input  1  1 = write, 0 = read
- r0_wdata / r1_wdata  input  DW  write data
- r0_wstrb / r1_wstrb  input  DW/8  byte enables
- r0_s_valid / r1_s_valid  output  1  response valid to requester
- r0_s_ready / r1_s_ready  input  1  requester accepts response
- r0_s_data / r1_s_data  output  DW  response data (broadcast of mem_s_data)
- mem_valid  output  1  registered request valid
- mem_ready  input  1  memory accepts request
- mem_addr, mem_we, mem_wdata, mem_wstrb  output  AW/1/DW/DW/8  registered request fields
- mem_s_valid  input  1  memory response valid
- mem_s_ready  output  1  response accepted
- mem_s_data  input  DW  response data
- error  output  1  sticky: response arrived with no outstanding entry

Behaviour:
- Handshakes: a transfer occurs when valid & ready are high on the same clock edge. Every request, read or write, yields exactly one response beat; a write response carries don't-care data.
- Reset values: mem_valid=0, ID FIFO empty (count=0), error=0, RR pointer last=1 (r0 wins the first tie). Outstanding transactions are discarded on reset.
- Grant condition: slot_free = !mem_valid | mem_ready; can_grant = slot_free & (count < DEPTH).
  - The DEPTH check ignores a same-cycle pop, so the block is conservative when full.
- rN_ready is combinational: asserted only for the winner, and only when can_grant.
  - rN_ready must not depend on the other requester's ready.
  - rN_ready may depend on both rX_valid inputs.
- On grant:
  - The output register loads the winner's fields; mem_valid=1 on the next cycle (request latency 1).
  - The winner's ID (0/1) is pushed to the FIFO.
- Output register: holds stable while mem_valid & !mem_ready. It clears when mem_valid & mem_ready and there is no new grant.
- Response routing, with head = FIFO head ID:
  - rN_s_valid = mem_s_valid & (count ≠ 0) & (head == N).
  - mem_s_ready = (count ≠ 0) ? r[head]_s_ready : 1.
  - Pop on mem_s_valid & mem_s_ready & (count ≠ 0).
- Same-cycle push and pop: count is unchanged; pointers advance independently and wrap modulo DEPTH.
- Response with count==0: accepted and dropped (mem_s_ready=1), error←1. error is cleared only by reset.
- Zero-latency memory (response on the cycle after the request handshake) is supported; push always precedes the matching pop.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on contention, the requester not granted last wins. last updates on every grant, including uncontended ones.
- Undefined: fixed priority, r1 (data) always beats r0; the last register is absent.

Decomposition:
- Package mem_arb_pkg:
  - typedef req_t (addr, we, wdata, wstrb) packed struct;
  - typedef id_t (1 bit);
  - localparams AW_DEF, DW_DEF, DEPTH_DEF.
- Sub-module mem_arb_id_fifo:
  - DEPTH×1-bit sync FIFO with push/pop/count/head;
  - ptr width clog2(DEPTH), count width clog2(DEPTH)+1.

Test Plan:
- Single read: r0 reads 0x200 while memory is always ready, then responds 0x1234_5678 next cycle → mem_addr=0x200 one cycle after r0_ready; r0_s_valid with data 0x12345678; r1_s_valid stays 0.
- Contention, RR defined: both valid on back-to-back cycles after reset → grant order r0,r1,r0,r1; FIFO IDs match; responses route in that order.
- Contention, RR undefined: both valid continuously → r1 granted every cycle, r0_ready never high.
- Backpressure: mem_ready=0 for 3 cycles with a pending request → mem_* fields stable, rN_ready=0 throughout, no extra push; DEPTH=4 stalls grants when count=4.
- Response stall: head=r1, r1_s_ready=0 for 2 cycles → mem_s_ready=0, no pop, r0_s_valid=0; released on r1_s_ready=1.
- Error and reset: mem_s_valid with empty FIFO → mem_s_ready=1, error=1 next cycle. Assert reset with 2 outstanding → count=0, mem_valid=0, error=0 the cycle after.
